// File: rtl/res_station_pkg.sv
// Shared types for the Tomasulo reservation stations.
//   XLEN / TAG_W : operand width and ROB tag width (8 ROB entries)
//   alu_ops      : operations an ALU can be asked to perform
//   ctl_word     : control word handed over by the issue queue
//   rs_state_t   : reservation-station occupancy state
package tomasula_types;

    localparam int XLEN  = 32;
    localparam int TAG_W = 3;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ops;

    typedef struct packed {
        alu_ops            op;
        logic [TAG_W-1:0]  rob_tag;
        logic              use_imm;
        logic [XLEN-1:0]   imm;
        logic [4:0]        src1;
        logic [4:0]        src2;
    } ctl_word;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } rs_state_t;

endpackage

// File: rtl/res_station_operand.sv
// One source operand slot of a reservation station.
// Holds valid/tag/value, captures the operand at load time (with a
// same-cycle CDB bypass) and snoops the CDB while waiting.
//   clear_i        : drop the operand (flush or entry freed); highest priority
//   load_i         : capture busy_i/tag_i/value_i this edge
//   busy_i, tag_i, value_i : operand source at load
//   snoop_i        : station is waiting; allow CDB capture
//   cdb_*_i        : common data bus broadcast
//   valid_o, value_o : registered operand state
//   valid_d_o      : operand validity after this edge (feeds the FSM)
module rs_operand
    import tomasula_types::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             busy_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [XLEN-1:0]  value_i,
    input  logic             snoop_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]  cdb_value_i,
    output logic             valid_o,
    output logic             valid_d_o,
    output logic [XLEN-1:0]  value_o
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  value_q, value_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        value_d = value_q;
        if (clear_i) begin
            valid_d = 1'b0;
            tag_d   = '0;
            value_d = '0;
        end else if (load_i) begin
            tag_d = tag_i;
            if (!busy_i) begin
                valid_d = 1'b1;
                value_d = value_i;
            end else if (cdb_valid_i && (cdb_tag_i == tag_i)) begin
                // Producer broadcasts in the very cycle we are issued.
                valid_d = 1'b1;
                value_d = cdb_value_i;
            end else begin
                valid_d = 1'b0;
                value_d = '0;
            end
        end else if (snoop_i && !valid_q && cdb_valid_i && (cdb_tag_i == tag_q)) begin
            // Gate on !valid_q: tag 0 is a real tag, and a captured value
            // must never be replaced by a later broadcast.
            valid_d = 1'b1;
            value_d = cdb_value_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            value_q <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            value_q <= value_d;
        end
    end

    assign valid_o   = valid_q;
    assign valid_d_o = valid_d;
    assign value_o   = value_q;

endmodule

// File: rtl/res_station.sv
// Single-entry Tomasulo reservation station.
// Captures an issued op and its operands, waits on the CDB for missing
// operands, then offers the op to the ALU.
// Handshake: alu_valid/alu_ready; the op transfers on any clock edge where
// both are 1. While alu_valid=1 and alu_ready=0, alu_op/alu_a/alu_b/
// alu_dest_tag hold stable. alu_valid never drops without a transfer,
// except on flush or reset.
//   clk, rst          : clock, asynchronous active-high reset
//   load, control_i   : issue-queue load pulse and control word
//   rs1_*, rs2_*      : register-file operand sources
//   cdb_*             : common data bus
//   flush             : squash the entry
//   alu_ready         : ALU accepts
//   empty             : station free (registered, no input path)
//   alu_valid, alu_op, alu_a, alu_b, alu_dest_tag : ALU request
//   state_o           : current state, for debug
module res_station
    import tomasula_types::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  ctl_word          control_i,
    input  logic             rs1_busy,
    input  logic [TAG_W-1:0] rs1_tag,
    input  logic [XLEN-1:0]  rs1_value,
    input  logic             rs2_busy,
    input  logic [TAG_W-1:0] rs2_tag,
    input  logic [XLEN-1:0]  rs2_value,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             flush,
    input  logic             alu_ready,
    output logic             empty,
    output logic             alu_valid,
    output alu_ops           alu_op,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [TAG_W-1:0] alu_dest_tag,
    output rs_state_t        state_o
);

    rs_state_t        state_q, state_d;
    alu_ops           op_q;
    logic [TAG_W-1:0] dest_q;

    logic load_en, clear, snoop;
    logic a_valid, a_valid_d, b_valid, b_valid_d;
    logic b_busy;
    logic [XLEN-1:0] b_src;

    // Register-select fields are decoded upstream; not needed here.
    logic unused_src;
    assign unused_src = ^{control_i.src1, control_i.src2};

    assign load_en = load && (state_q == EMPTY) && !flush;
    assign clear   = flush || ((state_q == READY) && alu_ready);
    assign snoop   = (state_q == WAIT);

    // An immediate replaces src2 outright; rs2_* are don't-care then.
    assign b_busy = rs2_busy && !control_i.use_imm;
    assign b_src  = control_i.use_imm ? control_i.imm : rs2_value;

    rs_operand u_src1 (
        .clk(clk), .rst(rst), .clear_i(clear), .load_i(load_en),
        .busy_i(rs1_busy), .tag_i(rs1_tag), .value_i(rs1_value),
        .snoop_i(snoop), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_value_i(cdb_value),
        .valid_o(a_valid), .valid_d_o(a_valid_d), .value_o(alu_a)
    );

    rs_operand u_src2 (
        .clk(clk), .rst(rst), .clear_i(clear), .load_i(load_en),
        .busy_i(b_busy), .tag_i(rs2_tag), .value_i(b_src),
        .snoop_i(snoop), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_value_i(cdb_value),
        .valid_o(b_valid), .valid_d_o(b_valid_d), .value_o(alu_b)
    );

    logic unused_valid;
    assign unused_valid = a_valid ^ b_valid;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (load) state_d = (a_valid_d && b_valid_d) ? READY : WAIT;
                WAIT:    if (a_valid_d && b_valid_d) state_d = READY;
                READY:   if (alu_ready) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            op_q    <= ALU_ADD;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                op_q   <= control_i.op;
                dest_q <= control_i.rob_tag;
            end
        end
    end

    assign empty        = (state_q == EMPTY);
    assign alu_valid    = (state_q == READY);
    assign alu_op       = op_q;
    assign alu_dest_tag = dest_q;
    assign state_o      = state_q;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(load && (state_q != EMPTY)))
                else $warning("res_station: load while occupied ignored");
        end
    end

endmodule

// File: doc/res_station.md
Name: res_station

Overview:
- Single-entry Tomasulo reservation station; four instances (res1..res4) sit directly downstream of the instruction issue queue.
- Loads a control word plus source operands when the issue queue pulses its load, then snoops the common data bus (CDB) for outstanding operands.
- Once both operands are valid, presents the op to its ALU with a valid/ready handshake.
- Reports empty back to the issue queue; frees the entry when the ALU accepts.

Parameters:
- XLEN, 32, operand/data width
- TAG_W, 3, ROB tag width (8 ROB entries)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load  in  1  issue-queue load pulse for this station
- control_i  in  tomasula_types::ctl_word  issued control word; fields used: op, rob_tag, use_imm, imm
- rs1_busy  in  1  regfile: src1 awaiting producer
- rs1_tag  in  TAG_W  regfile: ROB tag of src1 producer
- rs1_value  in  XLEN  regfile: src1 value
- rs2_busy, rs2_tag, rs2_value  in  1/TAG_W/XLEN  same for src2
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB ROB tag
- cdb_value  in  XLEN  CDB result
- flush  in  1  squash entry
- alu_ready  in  1  ALU accepts
- empty  out  1  station free; feeds the issue queue
- alu_valid  out  1  op ready for ALU
- alu_op  out  tomasula_types::alu_ops  operation
- alu_a, alu_b  out  XLEN  operands
- alu_dest_tag  out  TAG_W  ROB tag for CDB write-back

Behaviour:
- Reset: state EMPTY; empty=1, alu_valid=0; op/operands/tags cleared to 0. Reset applies asynchronously at any point, including mid-wait or mid-handshake.
- States:
  - EMPTY: empty=1.
  - WAIT: operand(s) outstanding.
  - READY: alu_valid=1.
- EMPTY, load=1:
  - Capture op and rob_tag.
  - Per operand: if busy=0, latch value and mark valid; else latch tag and mark invalid.
  - use_imm=1: src2 is imm, valid, and rs2_* is ignored.
- Same-cycle bypass at load: if cdb_valid and the busy operand's tag equals cdb_tag, latch cdb_value as valid.
- Next state after load: READY if both operands are valid, else WAIT.
- Latency: load at edge N with operands available gives alu_valid=1 after edge N.
- WAIT:
  - Each edge with cdb_valid, for each invalid operand whose tag==cdb_tag, latch cdb_value and mark valid.
  - Both operands may match the same broadcast.
  - Go to READY when both are valid.
  - Valid operands are never overwritten.
- READY:
  - alu_valid=1; alu_* driven from registers and held stable while alu_ready=0.
  - alu_valid=1 and alu_ready=1 at an edge → EMPTY; empty=1 from the next cycle.
  - CDB traffic is ignored.
- load while not EMPTY: ignored, state unchanged; simulation assertion fires.
- flush=1: next state EMPTY from any state; overrides load, CDB and handshake in the same cycle.
- empty and alu_valid are decoded from the state register only (no combinational path from inputs), so the issue queue sees no loop through empty.
- Tag 0 is a legal tag; matching uses the operand-valid bit, never tag==0.

Decomposition:
- tomasula_types holds:
  - ctl_word (op, rob_tag, use_imm, imm, src regs).
  - alu_ops enum.
  - rs_state_t enum {EMPTY, WAIT, READY}.
  - TAG_W/XLEN constants.
- One natural sub-module, rs_operand, used twice. It holds valid/tag/value, load-time capture, and CDB snoop with bypass.

Test Plan:
- Both ready: load, op=ADD, rs1_value=5, rs2_value=7, busy=0, alu_ready=1 → alu_valid next cycle with a=5, b=7; empty=1 one cycle after the handshake.
- CDB wake-up: load with rs1_busy=1, rs1_tag=3 → WAIT; cdb_tag=2 broadcast → no change; cdb_tag=3, value=0xDEAD → alu_valid next cycle, a=0xDEAD.
- Same-cycle bypass and dual match: load with rs1_tag=4 and rs2_tag=4 both busy, while cdb_valid, tag=4, value=9 → READY immediately, a=b=9.
- Immediate and backpressure: use_imm=1, imm=0x10, rs2_busy=1 → READY, b=0x10. Hold alu_ready=0 for 3 cycles → outputs stable, empty=0. Then accept → EMPTY.
- Flush priority: flush in WAIT with coincident matching CDB → EMPTY, no alu_valid. flush with load in EMPTY → stays EMPTY.
- Async reset mid-READY: assert rst between edges → empty=1 and alu_valid=0 immediately. Load while READY → ignored, assertion fires.
